// File: rtl/ds2411_id_sequencer_if.sv
// Bit-level 1-Wire PHY handshake between the DS2411 ID sequencer (master) and the PHY (slave).
interface ds2411_id_sequencer_if;
    logic       phy_req;
    logic [1:0] phy_op;
    logic       phy_wbit;
    logic       phy_done;
    logic       phy_rbit;

    modport master (
        output phy_req,
        output phy_op,
        output phy_wbit,
        input  phy_done,
        input  phy_rbit
    );

    modport slave (
        input  phy_req,
        input  phy_op,
        input  phy_wbit,
        output phy_done,
        output phy_rbit
    );
endinterface

// File: rtl/ds2411_id_sequencer.sv
// DS2411 serial-number readout: reset/presence, READ ROM (0x33), 64-bit ROM read,
// CRC-8 and family-code check, with retries on presence or CRC faults.
module ds2411_id_sequencer #(
    parameter logic [7:0]  FAMILY    = 8'h01,
    parameter bit          FAM_CHECK = 1'b1,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned RETRY_GAP = 1000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         go,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [1:0]                   err_code,
    output logic [63:0]                  result,
    ds2411_id_sequencer_if.master        phy
);

    localparam int unsigned BIT_W   = 6;
    localparam int unsigned RETRY_W = 4;
    localparam int unsigned GAP_W   = 16;
    localparam int unsigned ROM_W   = 64;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RST   = 3'd1;
    localparam logic [2:0] S_CMD   = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_FAIL  = 3'd5;
    localparam logic [2:0] S_GAP   = 3'd6;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;

    localparam logic [1:0] EC_NONE     = 2'd0;
    localparam logic [1:0] EC_PRESENCE = 2'd1;
    localparam logic [1:0] EC_CRC      = 2'd2;
    localparam logic [1:0] EC_FAMILY   = 2'd3;

    localparam logic [7:0] CMD_READ_ROM = 8'h33;
    localparam logic [7:0] CRC_POLY     = 8'h8C;

    logic [2:0]         state_q,    state_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               error_q,    error_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [1:0]         code_q,     code_d;
    logic [ROM_W-1:0]   result_q,   result_d;
    logic [ROM_W-1:0]   shift_q,    shift_d;
    logic [7:0]         crc_q,      crc_d;
    logic [BIT_W-1:0]   bit_q,      bit_d;
    logic [RETRY_W-1:0] retry_q,    retry_d;
    logic [GAP_W-1:0]   gap_q,      gap_d;
    logic               req_q,      req_d;
    logic [1:0]         op_q,       op_d;
    logic               wbit_q,     wbit_d;

    logic               fire_c;
    logic               fb_c;

    // A transaction completes only while our request is up; stray phy_done is ignored.
    assign fire_c = req_q & phy.phy_done;
    assign fb_c   = crc_q[0] ^ phy.phy_rbit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= EC_NONE;
            code_q     <= EC_NONE;
            result_q   <= '0;
            shift_q    <= '0;
            crc_q      <= '0;
            bit_q      <= '0;
            retry_q    <= '0;
            gap_q      <= '0;
            req_q      <= 1'b0;
            op_q       <= OP_RESET;
            wbit_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            code_q     <= code_d;
            result_q   <= result_d;
            shift_q    <= shift_d;
            crc_q      <= crc_d;
            bit_q      <= bit_d;
            retry_q    <= retry_d;
            gap_q      <= gap_d;
            req_q      <= req_d;
            op_q       <= op_d;
            wbit_q     <= wbit_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        err_code_d = err_code_q;
        code_d     = code_q;
        result_d   = result_q;
        shift_d    = shift_q;
        crc_d      = crc_q;
        bit_d      = bit_q;
        retry_d    = retry_q;
        gap_d      = gap_q;
        req_d      = req_q;
        op_d       = op_q;
        wbit_d     = wbit_q;

        case (state_q)
            S_IDLE: begin
                // busy still high here means this is the done/error cycle
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (go) begin
                    busy_d     = 1'b1;
                    err_code_d = EC_NONE;
                    retry_d    = '0;
                    bit_d      = '0;
                    crc_d      = '0;
                    req_d      = 1'b1;
                    op_d       = OP_RESET;
                    state_d    = S_RST;
                end
            end
            S_RST: begin
                if (fire_c) begin
                    req_d = 1'b0;
                    bit_d = '0;
                    if (phy.phy_rbit) begin
                        state_d = S_CMD;
                    end else begin
                        code_d  = EC_PRESENCE;
                        state_d = S_FAIL;
                    end
                end
            end
            S_CMD: begin
                if (fire_c) begin
                    req_d = 1'b0;
                    if (bit_q == BIT_W'(7)) begin
                        bit_d   = '0;
                        state_d = S_READ;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else if (!req_q) begin
                    req_d  = 1'b1;
                    op_d   = OP_WRITE;
                    wbit_d = CMD_READ_ROM[bit_q[2:0]];
                end
            end
            S_READ: begin
                if (fire_c) begin
                    req_d   = 1'b0;
                    shift_d = {phy.phy_rbit, shift_q[ROM_W-1:1]};
                    crc_d   = {1'b0, crc_q[7:1]} ^ (fb_c ? CRC_POLY : 8'h00);
                    if (bit_q == BIT_W'(ROM_W - 1)) begin
                        bit_d   = '0;
                        state_d = S_CHECK;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else if (!req_q) begin
                    req_d = 1'b1;
                    op_d  = OP_READ;
                end
            end
            S_CHECK: begin
                if (crc_q != 8'h00) begin
                    code_d  = EC_CRC;
                    state_d = S_FAIL;
                end else if (FAM_CHECK && (shift_q[7:0] != FAMILY)) begin
                    code_d  = EC_FAMILY;
                    state_d = S_FAIL;
                end else begin
                    result_d = shift_q;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_FAIL: begin
                // Family mismatch is a real answer from the part, so it never retries.
                if ((code_q != EC_FAMILY) && (retry_q < RETRY_W'(MAX_RETRY))) begin
                    retry_d = retry_q + RETRY_W'(1);
                    gap_d   = '0;
                    state_d = S_GAP;
                end else begin
                    err_code_d = code_q;
                    error_d    = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(RETRY_GAP - 1)) begin
                    bit_d   = '0;
                    crc_d   = '0;
                    req_d   = 1'b1;
                    op_d    = OP_RESET;
                    state_d = S_RST;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_code_q;
    assign result       = result_q;
    assign phy.phy_req  = req_q;
    assign phy.phy_op   = op_q;
    assign phy.phy_wbit = wbit_q;

endmodule

// File: tb/tb_ds2411_id_sequencer.sv
// Directed bench for ds2411_id_sequencer with a behavioural 1-Wire PHY answering one cycle after each request.
module tb_ds2411_id_sequencer;

    localparam logic [63:0] ROM_GOOD = 64'hA200_0000_01B8_1C02;
    localparam logic [63:0] ROM_BAD  = 64'hA300_0000_01B8_1C02;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        go;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [63:0] result;

    ds2411_id_sequencer_if ifc();

    ds2411_id_sequencer #(
        .FAMILY    (8'h02),
        .FAM_CHECK (1'b1),
        .MAX_RETRY (3),
        .RETRY_GAP (10)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .go       (go),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code),
        .result   (result),
        .phy      (ifc.master)
    );

    always #5 clk = ~clk;

    // PHY model state
    logic        clr;
    logic        presence;
    logic [63:0] rom_a, rom_b;
    logic        model_done;
    logic        stray_done;
    int          n_reset, n_write, n_read, read_idx, idle_run, min_idle;
    logic [7:0]  wr_byte;
    logic [1:0]  first_op;
    logic        first_seen;

    assign ifc.phy_done = model_done | stray_done;

    // First attempt reads rom_a, every retry reads rom_b.
    always @(posedge clk) begin
        if (clr) begin
            n_reset    <= 0;
            n_write    <= 0;
            n_read     <= 0;
            read_idx   <= 0;
            idle_run   <= 0;
            min_idle   <= 100000;
            wr_byte    <= 8'h00;
            first_op   <= 2'd3;
            first_seen <= 1'b0;
            model_done <= 1'b0;
        end else begin
            model_done <= 1'b0;
            idle_run   <= ifc.phy_req ? 0 : idle_run + 1;
            if (ifc.phy_req && !model_done) begin
                model_done <= 1'b1;
                if (!first_seen) begin
                    first_seen <= 1'b1;
                    first_op   <= ifc.phy_op;
                end
                case (ifc.phy_op)
                    2'd0: begin
                        ifc.phy_rbit <= presence;
                        read_idx     <= 0;
                        n_reset      <= n_reset + 1;
                        if (n_reset != 0 && idle_run < min_idle) min_idle <= idle_run;
                    end
                    2'd1: begin
                        if (n_write < 8) wr_byte[n_write[2:0]] <= ifc.phy_wbit;
                        n_write <= n_write + 1;
                    end
                    2'd2: begin
                        ifc.phy_rbit <= (n_reset <= 1) ? rom_a[read_idx[5:0]] : rom_b[read_idx[5:0]];
                        read_idx     <= read_idx + 1;
                        n_read       <= n_read + 1;
                    end
                    default: ;
                endcase
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0; go = 1'b1;
        @(negedge clk); go = 1'b0;
    endtask

    // Wait for the done/error cycle, then sample busy one cycle later.
    task automatic wait_end(input int budget, output logic got_done, output logic got_err,
                            output logic busy_at, output logic busy_after);
        got_done = 1'b0; got_err = 1'b0; busy_at = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done || error) begin
                got_done = done; got_err = error; busy_at = busy;
                break;
            end
        end
        @(negedge clk);
        busy_after = busy;
    endtask

    logic gd, ge, ba, bf;

    initial begin
        reset_n = 1'b0; go = 1'b0; clr = 1'b1; presence = 1'b1;
        stray_done = 1'b0; rom_a = ROM_GOOD; rom_b = ROM_GOOD;
        ifc.phy_rbit = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_pulse", 64'({done, error}), 64'd0);
        chk("rst_phy",   64'({ifc.phy_req, ifc.phy_op, ifc.phy_wbit}), 64'd0);
        chk("rst_ecode", 64'(err_code), 64'd0);
        chk("rst_result", result, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: good ROM, family 0x02
        start();
        wait_end(400, gd, ge, ba, bf);
        chk("t1_done",   64'({gd, ge}), 64'b10);
        chk("t1_busy",   64'({ba, bf}), 64'b10);
        chk("t1_wbits",  64'(wr_byte), 64'h33);
        chk("t1_counts", 64'({n_reset[7:0], n_write[7:0], n_read[7:0]}), 64'h01_08_40);
        chk("t1_result", result, 64'hA200_0000_01B8_1C02);
        chk("t1_ecode",  64'(err_code), 64'd0);

        // 4: all-zero ROM has zero CRC residue, rejected by family, no retry
        rom_a = 64'd0; rom_b = 64'd0;
        start();
        wait_end(400, gd, ge, ba, bf);
        chk("t4_error",  64'({gd, ge}), 64'b01);
        chk("t4_ecode",  64'(err_code), 64'd3);
        chk("t4_nreset", 64'(n_reset), 64'd1);
        chk("t4_result", result, ROM_GOOD);

        // 3: bad CRC first, good on retry
        rom_a = ROM_BAD; rom_b = ROM_GOOD;
        start();
        wait_end(800, gd, ge, ba, bf);
        chk("t3_done",   64'({gd, ge}), 64'b10);
        chk("t3_counts", 64'({n_reset[7:0], n_read[7:0]}), 64'h02_80);
        chk("t3_ecode",  64'(err_code), 64'd0);

        // 2: no presence at all
        presence = 1'b0;
        start();
        wait_end(400, gd, ge, ba, bf);
        chk("t2_error",  64'({gd, ge}), 64'b01);
        chk("t2_busy",   64'({ba, bf}), 64'b10);
        chk("t2_ecode",  64'(err_code), 64'd1);
        chk("t2_counts", 64'({n_reset[7:0], n_write[7:0], n_read[7:0]}), 64'h04_00_00);
        chk("t2_gap_ok", 64'(min_idle >= 10), 64'd1);
        chk("t2_result", result, ROM_GOOD);
        presence = 1'b1;

        // CRC fails on every attempt: retries exhausted, code 2 held until next go
        rom_a = ROM_BAD; rom_b = ROM_BAD;
        start();
        wait_end(2000, gd, ge, ba, bf);
        chk("tc_error",  64'({gd, ge}), 64'b01);
        chk("tc_nreset", 64'(n_reset), 64'd4);
        repeat (5) @(negedge clk);
        chk("tc_ecode_held", 64'(err_code), 64'd2);

        // 5: reset during READ bit 30
        rom_a = ROM_GOOD; rom_b = ROM_GOOD;
        start();
        chk("t5_ecode_clr", 64'(err_code), 64'd0);
        for (int i = 0; i < 400; i++) begin
            if (n_read >= 30) break;
            @(negedge clk);
        end
        chk("t5_at_bit30", 64'(n_read), 64'd30);
        reset_n = 1'b0;
        #1;
        chk("t5_abort", 64'({ifc.phy_req, busy}), 64'd0);
        @(negedge clk); reset_n = 1'b1;
        start();
        wait_end(400, gd, ge, ba, bf);
        chk("t5_first_op", 64'(first_op), 64'd0);
        chk("t5_done",     64'({gd, ge}), 64'b10);
        chk("t5_result",   result, ROM_GOOD);

        // 6: go while busy and a stray phy_done while phy_req is low
        start();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (n_read >= 10 && !ifc.phy_req) break;
        end
        stray_done = 1'b1; go = 1'b1;
        @(negedge clk);
        stray_done = 1'b0; go = 1'b0;
        wait_end(400, gd, ge, ba, bf);
        chk("t6_done",   64'({gd, ge}), 64'b10);
        chk("t6_result", result, ROM_GOOD);
        chk("t6_counts", 64'({n_reset[7:0], n_read[7:0]}), 64'h01_40);
        repeat (30) @(negedge clk);
        chk("t6_quiet",  64'({busy, ifc.phy_req, 8'(n_reset)}), 64'h001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
